// File: rtl/ysyx_22050243_isram_if.sv
// Fetch and backing-memory bus for the instruction SRAM responder.
//
// Fetch side : isram_e, isram_addr, flush       (core -> responder)
//              isram_rdata, isram_rvalid,
//              isram_err, stall_req             (responder -> core)
// Memory side: mem_req, mem_addr                (responder -> memory)
//              mem_ack, mem_rdata, mem_err      (memory -> responder)
//
// The slave modport is the responder. The master modport is the core/memory
// environment around it.
interface ysyx_22050243_isram_if;
   logic        isram_e;
   logic [63:0] isram_addr;
   logic        flush;
   logic [31:0] isram_rdata;
   logic        isram_rvalid;
   logic        isram_err;
   logic        stall_req;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ack;
   logic [63:0] mem_rdata;
   logic        mem_err;

   modport slave (
      input  isram_e, isram_addr, flush, mem_ack, mem_rdata, mem_err,
      output isram_rdata, isram_rvalid, isram_err, stall_req, mem_req, mem_addr
   );

   modport master (
      output isram_e, isram_addr, flush, mem_ack, mem_rdata, mem_err,
      input  isram_rdata, isram_rvalid, isram_err, stall_req, mem_req, mem_addr
   );
endinterface

// File: rtl/ysyx_22050243_isram.sv
// Instruction-side SRAM responder with a one-line (two instruction) buffer
// in front of a variable-latency backing read port.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - ysyx_22050243_isram_if.slave
//          fetch request (isram_e/isram_addr/flush), 1-cycle registered
//          response (isram_rdata/isram_rvalid/isram_err), combinational
//          stall_req, and the backing read port (mem_req/mem_addr out,
//          mem_ack/mem_rdata/mem_err in).
//
// A hit or a misaligned fetch answers on the next cycle without stalling.
// A miss stalls fetch, issues one line read, installs the line, and lets the
// held request hit on the cycle after the fill completes. A backing error is
// reported through a one-cycle ERR state.
module ysyx_22050243_isram #(
   parameter logic [31:0] NOP_INST   = 32'h0000_0013,
   parameter int          LINE_BYTES = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   ysyx_22050243_isram_if.slave    bus
);

   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int TAG_W = 64 - OFF_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      ERR  = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;

   logic               buf_valid;
   logic [TAG_W-1:0]   buf_tag;
   logic [63:0]        buf_data;
   logic               fill_discard;

   logic [31:0]        rdata_q;
   logic               rvalid_q;
   logic               err_q;
   logic               mem_req_q;
   logic [63:0]        mem_addr_q;

   logic [TAG_W-1:0]   req_tag;
   logic               hit;
   logic               misal;
   logic               miss;
   logic               discard_now;
   logic               install;
   logic               stall;

   assign req_tag = bus.isram_addr[63:OFF_W];

   // Misalignment takes priority over the tag compare; hit is only
   // meaningful in IDLE so a stale buffer cannot answer during a fill.
   assign misal = bus.isram_e & (bus.isram_addr[1:0] != 2'b00);
   assign hit   = bus.isram_e & buf_valid & (buf_tag == req_tag)
                  & (state_q == IDLE);
   assign miss  = bus.isram_e & ~misal & ~hit & (state_q == IDLE);

   // A flush arriving on the ack cycle itself also blocks the install.
   assign discard_now = fill_discard | bus.flush;
   assign install     = (state_q == FILL) & bus.mem_ack & ~bus.mem_err
                        & ~discard_now;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (miss) begin
               state_d = FILL;
            end
         end
         FILL: begin
            if (bus.mem_ack) begin
               state_d = bus.mem_err ? ERR : IDLE;
            end
         end
         ERR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Stall is combinational so the core holds the PC in the miss cycle
   // itself. ERR deliberately does not stall.
   always_comb begin
      stall = 1'b0;
      if (!rst) begin
         if (state_q == FILL) begin
            stall = 1'b1;
         end else if (miss) begin
            stall = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Control and response registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         buf_valid    <= 1'b0;
         fill_discard <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= 64'd0;
         rvalid_q     <= 1'b0;
         err_q        <= 1'b0;
         rdata_q      <= NOP_INST;
      end else begin
         state_q  <= state_d;
         rvalid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.flush) begin
                  buf_valid <= 1'b0;
               end
               if (misal) begin
                  rvalid_q <= 1'b1;
                  err_q    <= 1'b1;
                  rdata_q  <= NOP_INST;
               end else if (hit) begin
                  rvalid_q <= 1'b1;
                  err_q    <= 1'b0;
                  rdata_q  <= bus.isram_addr[OFF_W-1] ? buf_data[63:32]
                                                      : buf_data[31:0];
               end else if (miss) begin
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= {req_tag, {OFF_W{1'b0}}};
               end
            end
            FILL: begin
               if (bus.flush) begin
                  fill_discard <= 1'b1;
                  buf_valid    <= 1'b0;
               end
               if (bus.mem_ack) begin
                  mem_req_q    <= 1'b0;
                  fill_discard <= 1'b0;
                  if (install) begin
                     buf_valid <= 1'b1;
                  end
               end
            end
            ERR: begin
               rvalid_q <= 1'b1;
               err_q    <= 1'b1;
               rdata_q  <= NOP_INST;
               if (bus.flush) begin
                  buf_valid <= 1'b0;
               end
            end
            default: begin
               rvalid_q <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Line buffer storage (qualified by buf_valid, so no reset needed)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (install) begin
         buf_data <= bus.mem_rdata;
         buf_tag  <= bus.mem_addr[63:OFF_W];
      end
   end

   assign bus.isram_rdata  = rdata_q;
   assign bus.isram_rvalid = rvalid_q;
   assign bus.isram_err    = err_q;
   assign bus.stall_req    = stall;
   assign bus.mem_req      = mem_req_q;
   assign bus.mem_addr     = mem_addr_q;

endmodule

// File: doc/ysyx_22050243_isram.md
Name: ysyx_22050243_isram

Overview:
- Instruction-side SRAM responder: serves fetch requests issued on the isram_e/isram_addr interface and returns one 32-bit instruction per hit.
- Holds a one-doubleword line buffer (two instructions) in front of a variable-latency backing memory port.
- Raises stall_req, the fetch-stall bit of the stall bus, while a miss is outstanding; the fetch PC is held constant during the stall.

Parameters:
- NOP_INST, 32'h0000_0013, instruction driven on isram_rdata after reset and on error responses.
- LINE_BYTES, 8, backing-port line size in bytes; fixed. Tag is addr[63:3] and word select is addr[2].

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- isram_e  in  1  fetch request valid, sampled each cycle.
- isram_addr  in  64  fetch byte address.
- flush  in  1  invalidate the line buffer (fence.i); 1-cycle pulse.
- isram_rdata  out  32  returned instruction.
- isram_rvalid  out  1  isram_rdata/isram_err valid this cycle.
- isram_err  out  1  response is a fault: misaligned address or backing error.
- stall_req  out  1  fetch stall request; combinational.
- mem_req  out  1  backing read request; registered, held until mem_ack.
- mem_addr  out  64  backing line address, always 8-byte aligned.
- mem_ack  in  1  backing read done, single-cycle pulse.
- mem_rdata  in  64  backing line data, valid with mem_ack.
- mem_err  in  1  backing error, qualified by mem_ack.

Behaviour:
- State: FSM {IDLE, FILL, ERR}, buf_valid, buf_tag[60:0], buf_data[63:0], fill_discard.
- Reset values:
  - state IDLE, buf_valid 0, fill_discard 0.
  - isram_rdata NOP_INST, isram_rvalid 0, isram_err 0.
  - mem_req 0, mem_addr 0, stall_req 0.
- Reset mid-FILL drops mem_req the same edge. A late mem_ack arriving in IDLE is ignored.
- hit = isram_e & buf_valid & (buf_tag == isram_addr[63:3]) & (state == IDLE).
- misal = isram_e & (isram_addr[1:0] != 0).
- Hit at cycle t: at t+1, isram_rvalid=1, isram_err=0, isram_rdata = buf_data[63:32] if addr[2]=1, else buf_data[31:0]. Latency is 1 cycle, full throughput, no stall.
- Misaligned at t: checked before tag compare, with no memory access. At t+1, isram_rvalid=1, isram_err=1, isram_rdata=NOP_INST.
- Miss at t (isram_e, aligned, !hit, state IDLE):
  - stall_req=1 combinationally in cycle t.
  - Edge after t: state FILL, mem_req=1, mem_addr = {isram_addr[63:3], 3'b0}.
- FILL: stall_req=1 every cycle; mem_req and mem_addr are stable until mem_ack.
- mem_ack & !mem_err & !fill_discard: write buf_data/buf_tag, set buf_valid, drop mem_req, go IDLE. The held request hits the next cycle.
- mem_ack & mem_err: drop mem_req, go ERR; buffer unchanged.
- ERR, one cycle: stall_req=0. At the next edge, isram_rvalid=1, isram_err=1, isram_rdata=NOP_INST; then IDLE.
- isram_rvalid is 0 on every cycle not listed above. isram_rdata and isram_err hold their last values when isram_rvalid=0.
- flush:
  - In IDLE: clears buf_valid at the edge. A hit in the same cycle is still served (compare uses the pre-flush state).
  - In FILL: sets fill_discard. On ack, data is not installed, state returns IDLE, and the still-pending request misses again and refetches.
  - fill_discard clears on leaving FILL.
- isram_e=0 (including the reset-vector cycle, where address 0 is presented with e=0): no response, no stall, no memory access.
- Address change while stall_req=1 is a protocol violation and need not be handled.
- Simultaneous mem_ack with rst: rst wins.

Test Plan:
1. Cold miss then stream: isram_e=1, addr 0x8000_0000; mem_ack 3 cycles after mem_req with mem_rdata=0x00A0_0093_0000_0513.
   - stall_req high from cycle 0 through the ack cycle; mem_addr=0x8000_0000.
   - Next cycle rvalid=1, rdata=0x0000_0513.
   - Then addr 0x8000_0004 -> rdata=0x00A0_0093 with no stall.
2. Line crossing: buffer holds 0x8000_0000; request 0x8000_0008 -> stall, mem_addr=0x8000_0008, refill, correct word returned.
3. Backing error: miss at 0x8000_0010; mem_ack with mem_err=1 -> one ERR cycle with stall_req=0, then rvalid=1, err=1, rdata=0x0000_0013; buf_valid unchanged.
4. Misaligned: addr 0x8000_0002, e=1 -> next cycle rvalid=1, err=1, rdata=NOP; mem_req never asserted.
5. Flush during FILL: pulse flush 1 cycle after mem_req rises -> ack not installed, second mem_req to the same address issued, response delivered only after the second ack.
6. Reset mid-FILL: rst during FILL -> mem_req=0, stall_req=0, rvalid=0 next cycle; a stray mem_ack afterwards has no effect; first later fetch misses.
